// File: rtl/id_pkg.sv
// ============================================================================
// Module   : id_pkg
// Purpose  : Shared constants and helpers for the id_stage_pipe decode stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package id_pkg;

    // Compare-operand source selects
    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_EX   = 2'b10;
    localparam logic [1:0] FWD_ZERO = 2'b11;

    // Instruction field positions
    localparam int RS_LSB   = 21;
    localparam int RT_LSB   = 16;
    localparam int RD_LSB   = 11;
    localparam int JIDX_MSB = 25;

    // Fill bit used when widening imm16: sign bit or zero.
    function automatic logic imm_fill(input logic [15:0] imm16, input logic sext);
        return sext & imm16[15];
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_regfile.sv
// ============================================================================
// Module   : id_regfile
// Purpose  : 2-read 1-write register file, write-through reads, register 0 = 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_regfile
    import id_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] raddr_a_i,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);

    localparam int c_DEPTH = 1 << REG_AW;

    logic [DATA_W-1:0] mem_q [c_DEPTH];
    logic              w_wr_en;

    assign w_wr_en = we_i && (waddr_i != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_wr_en) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // A same-cycle WB write to the read address is bypassed to the reader.
    assign rdata_a_o = (raddr_a_i == '0)                   ? '0      :
                       (w_wr_en && waddr_i == raddr_a_i)   ? wdata_i :
                                                             mem_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0)                   ? '0      :
                       (w_wr_en && waddr_i == raddr_b_i)   ? wdata_i :
                                                             mem_q[raddr_b_i];

endmodule

`default_nettype wire

// File: rtl/id_stage_pipe.sv
// ============================================================================
// Module   : id_stage_pipe
// Purpose  : MIPS decode stage: regfile, branch compare forwarding, branch/jump
//            redirect, load-use stall and a valid/ready ID/EX register.
//            Define ID_STALL_CNT_EN to add the 32-bit stall_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_stage_pipe
    import id_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   pc,
    input  logic [31:0]       inst,
    input  logic              sign_ext,
    input  logic              is_branch,
    input  logic              is_jump,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] ex_out,
    input  logic [1:0]        fwd_a,
    input  logic [1:0]        fwd_b,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_rs_data,
    output logic [DATA_W-1:0] out_rt_data,
    output logic [DATA_W-1:0] out_imm,
    output logic [REG_AW-1:0] out_rs,
    output logic [REG_AW-1:0] out_rt,
    output logic [REG_AW-1:0] out_rd,
    output logic              cmp_eq,
    output logic              pc_redirect,
    output logic [PC_W-1:0]   pc_next
`ifdef ID_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    function automatic logic [DATA_W-1:0] f_fwd(input logic [1:0]        sel,
                                                 input logic [DATA_W-1:0] rf,
                                                 input logic [DATA_W-1:0] wb,
                                                 input logic [DATA_W-1:0] ex);
        case (sel)
            FWD_WB:   return wb;
            FWD_EX:   return ex;
            FWD_ZERO: return '0;
            default:  return rf;
        endcase
    endfunction

    logic [REG_AW-1:0] w_rs, w_rt, w_rd;
    logic [DATA_W-1:0] w_rs_data, w_rt_data, w_op_a, w_op_b, w_imm;
    logic [PC_W-1:0]   w_br_off, w_br_tgt, w_jmp_tgt;
    logic              w_fill, w_hazard, w_advance, w_in_ready, w_accept;
    logic              w_unused;

    assign w_rs     = inst[RS_LSB +: REG_AW];
    assign w_rt     = inst[RT_LSB +: REG_AW];
    assign w_rd     = inst[RD_LSB +: REG_AW];
    assign w_unused = ^inst;

    id_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we_i      (wb_we),
        .waddr_i   (wb_addr),
        .wdata_i   (wb_data),
        .raddr_a_i (w_rs),
        .raddr_b_i (w_rt),
        .rdata_a_o (w_rs_data),
        .rdata_b_o (w_rt_data)
    );

    assign w_fill = imm_fill(inst[15:0], sign_ext);
    assign w_imm  = {{(DATA_W-16){w_fill}}, inst[15:0]};

    assign w_op_a = f_fwd(fwd_a, w_rs_data, wb_data, ex_out);
    assign w_op_b = f_fwd(fwd_b, w_rt_data, wb_data, ex_out);
    assign cmp_eq = (w_op_a == w_op_b);

    assign w_hazard   = in_valid && ex_mem_read && (ex_rt != '0) &&
                        ((ex_rt == w_rs) || (ex_rt == w_rt));
    assign w_advance  = !out_valid || out_ready;
    assign w_in_ready = w_advance && !w_hazard;
    assign w_accept   = in_valid && !w_hazard;
    assign in_ready   = w_in_ready;

    assign w_br_off = {{(PC_W-18){w_fill}}, inst[15:0], 2'b00};
    assign w_br_tgt = pc + w_br_off;

    // Narrow PCs have no upper segment to carry into the jump target.
    generate
        if (PC_W > 28) begin : g_jmp_hi
            assign w_jmp_tgt = {pc[PC_W-1:28], inst[JIDX_MSB:0], 2'b00};
        end else begin : g_jmp_lo
            assign w_jmp_tgt = {inst[JIDX_MSB:0], 2'b00};
        end
    endgenerate

    assign pc_redirect = in_valid && w_in_ready && (is_jump || (is_branch && cmp_eq));
    assign pc_next     = is_jump ? w_jmp_tgt : w_br_tgt;

    logic              out_valid_q;
    logic [PC_W-1:0]   out_pc_q;
    logic [DATA_W-1:0] out_rs_data_q, out_rt_data_q, out_imm_q;
    logic [REG_AW-1:0] out_rs_q, out_rt_q, out_rd_q;

    // Bubbles clear only the valid bit; the payload keeps its last contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_pc_q      <= '0;
            out_rs_data_q <= '0;
            out_rt_data_q <= '0;
            out_imm_q     <= '0;
            out_rs_q      <= '0;
            out_rt_q      <= '0;
            out_rd_q      <= '0;
        end else if (w_advance) begin
            if (w_accept) begin
                out_valid_q   <= 1'b1;
                out_pc_q      <= pc;
                out_rs_data_q <= w_rs_data;
                out_rt_data_q <= w_rt_data;
                out_imm_q     <= w_imm;
                out_rs_q      <= w_rs;
                out_rt_q      <= w_rt;
                out_rd_q      <= w_rd;
            end else begin
                out_valid_q   <= 1'b0;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_pc_q;
    assign out_rs_data = out_rs_data_q;
    assign out_rt_data = out_rt_data_q;
    assign out_imm     = out_imm_q;
    assign out_rs      = out_rs_q;
    assign out_rt      = out_rt_q;
    assign out_rd      = out_rd_q;

`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign stall_cnt_d = stall_cnt_q + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (in_valid && !w_in_ready) begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
// ============================================================================
// Module   : tb_id_stage_pipe
// Purpose  : Self-checking bench for id_stage_pipe against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, sign_ext, is_branch, is_jump, wb_we;
    logic [31:0] pc, inst, wb_data, ex_out;
    logic [4:0]  wb_addr, ex_rt;
    logic [1:0]  fwd_a, fwd_b;
    logic        ex_mem_read, out_valid, out_ready, cmp_eq, pc_redirect;
    logic [31:0] out_pc, out_rs_data, out_rt_data, out_imm, pc_next;
    logic [4:0]  out_rs, out_rt, out_rd;
`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.DATA_W(32), .REG_AW(5), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc(pc), .inst(inst),
        .sign_ext(sign_ext), .is_branch(is_branch), .is_jump(is_jump), .wb_we(wb_we),
        .wb_addr(wb_addr), .wb_data(wb_data), .ex_out(ex_out), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imm(out_imm),
        .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .cmp_eq(cmp_eq),
        .pc_redirect(pc_redirect), .pc_next(pc_next)
`ifdef ID_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    // Reference model state
    logic [31:0] mrf [32];
    logic        e_valid;
    logic [31:0] e_pc, e_rs_data, e_rt_data, e_imm, e_stall;
    logic [4:0]  e_rs, e_rt, e_rd;

    function automatic logic [31:0] mk_inst(input logic [4:0] rs, input logic [4:0] rt,
                                            input logic [15:0] imm);
        return {6'h04, rs, rt, imm};
    endfunction

    function automatic logic [31:0] m_rf(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_we && wb_addr == a) return wb_data;
        return mrf[a];
    endfunction

    function automatic logic [31:0] m_op(input logic [1:0] sel, input logic [4:0] a);
        case (sel)
            2'd0:    return m_rf(a);
            2'd1:    return wb_data;
            2'd2:    return ex_out;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_hazard();
        return in_valid && ex_mem_read && ex_rt != 5'd0 &&
               (ex_rt == inst[25:21] || ex_rt == inst[20:16]);
    endfunction

    function automatic logic m_ready();
        return (!e_valid || out_ready) && !m_hazard();
    endfunction

    function automatic logic [31:0] m_imm();
        return sign_ext ? {{16{inst[15]}}, inst[15:0]} : {16'h0, inst[15:0]};
    endfunction

    function automatic logic m_cmp();
        return m_op(fwd_a, inst[25:21]) == m_op(fwd_b, inst[20:16]);
    endfunction

    function automatic logic m_redirect();
        return in_valid && m_ready() && (is_jump || (is_branch && m_cmp()));
    endfunction

    function automatic logic [31:0] m_pcnext();
        if (is_jump) return {pc[31:28], inst[25:0], 2'b00};
        return pc + m_imm() * 32'd4;
    endfunction

    // Advance the model by one clock using the current inputs, then clock the DUT.
    task automatic tick();
        if (rst) begin
            e_valid = 0; e_pc = 0; e_rs_data = 0; e_rt_data = 0; e_imm = 0;
            e_rs = 0; e_rt = 0; e_rd = 0; e_stall = 0;
            for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        end else begin
            if (in_valid && !m_ready()) e_stall = e_stall + 32'd1;
            if (!e_valid || out_ready) begin
                if (in_valid && !m_hazard()) begin
                    e_valid   = 1;
                    e_pc      = pc;
                    e_rs_data = m_rf(inst[25:21]);
                    e_rt_data = m_rf(inst[20:16]);
                    e_imm     = m_imm();
                    e_rs      = inst[25:21];
                    e_rt      = inst[20:16];
                    e_rd      = inst[15:11];
                end else begin
                    e_valid = 0;
                end
            end
            if (wb_we && wb_addr != 5'd0) mrf[wb_addr] = wb_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; in_valid = 0; pc = 0; inst = 0; sign_ext = 0; is_branch = 0; is_jump = 0;
        wb_we = 0; wb_addr = 0; wb_data = 0; ex_out = 0; fwd_a = 0; fwd_b = 0;
        ex_mem_read = 0; ex_rt = 0; out_ready = 1;
    endtask

    task automatic test_reset();
        idle(); rst = 1; tick(); rst = 0;
        wb_we = 1; wb_addr = 5; wb_data = 32'h1234_5678;
        in_valid = 1; pc = 32'h40; inst = mk_inst(5, 0, 16'h7); tick();
        wb_we = 0; rst = 1; tick(); rst = 0; in_valid = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %h want 0", out_valid); end
        checks++; if (out_pc !== 32'd0 || out_imm !== 32'd0) begin errors++; $display("FAIL rst_pc_imm got %h/%h want 0", out_pc, out_imm); end
        checks++; if (out_rs_data !== 32'd0 || out_rt_data !== 32'd0) begin errors++; $display("FAIL rst_data got %h/%h want 0", out_rs_data, out_rt_data); end
        checks++; if ({out_rs, out_rt, out_rd} !== 15'd0) begin errors++; $display("FAIL rst_addr got %h want 0", {out_rs, out_rt, out_rd}); end
        in_valid = 1; inst = mk_inst(5, 0, 16'h0); fwd_a = 2'b00; fwd_b = 2'b11; #1;
        checks++; if (cmp_eq !== 1'b1) begin errors++; $display("FAIL rst_r5_cmp got %b want 1", cmp_eq); end
        tick();
        checks++; if (out_rs_data !== 32'd0) begin errors++; $display("FAIL rst_r5_read got %h want 0", out_rs_data); end
    endtask

    task automatic test_regfile_wt();
        idle();
        wb_we = 1; wb_addr = 5; wb_data = 32'hDEAD_BEEF;
        in_valid = 1; pc = 32'h80; inst = mk_inst(5, 0, 16'h0); fwd_a = 2'b00; fwd_b = 2'b10;
        ex_out = 32'hDEAD_BEEF; #1;
        checks++; if (cmp_eq !== 1'b1) begin errors++; $display("FAIL wt_cmp got %b want 1", cmp_eq); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_rs_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wt_opa got %b/%h want 1/deadbeef", out_valid, out_rs_data); end
        wb_addr = 0; wb_data = 32'h1234; inst = mk_inst(0, 5, 16'h0); fwd_b = 2'b11; #1;
        checks++; if (cmp_eq !== 1'b1) begin errors++; $display("FAIL r0_wt_cmp got %b want 1", cmp_eq); end
        tick(); wb_we = 0;
        checks++; if (out_rs_data !== 32'd0 || out_rt_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL r0_read got %h/%h want 0/deadbeef", out_rs_data, out_rt_data); end
    endtask

    task automatic test_hazard();
        idle();
        ex_mem_read = 1; ex_rt = 3; in_valid = 1; pc = 32'h300; inst = mk_inst(3, 0, 16'h1);
        is_jump = 1; wb_we = 1; wb_addr = 3; wb_data = 32'hA5A5_0001; #1;
        checks++; if (in_ready !== 1'b0 || pc_redirect !== 1'b0) begin errors++; $display("FAIL hz_stall got rdy=%b redir=%b want 0/0", in_ready, pc_redirect); end
        tick(); wb_we = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hz_bubble got %b want 0", out_valid); end
        ex_mem_read = 0; #1;
        checks++; if (in_ready !== 1'b1 || pc_redirect !== 1'b1) begin errors++; $display("FAIL hz_release got rdy=%b redir=%b want 1/1", in_ready, pc_redirect); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h300 || out_rs_data !== 32'hA5A5_0001) begin errors++; $display("FAIL hz_accept got %b/%h/%h want 1/300/a5a50001", out_valid, out_pc, out_rs_data); end
        ex_mem_read = 1; ex_rt = 0; inst = mk_inst(0, 0, 16'h0); is_jump = 0; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hz_r0 got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_branch();
        idle();
        in_valid = 1; is_branch = 1; fwd_a = 2'b10; fwd_b = 2'b10; ex_out = 32'd7;
        pc = 32'h100; inst = mk_inst(1, 2, 16'hFFFF); sign_ext = 1; #1;
        checks++; if (cmp_eq !== 1'b1 || pc_redirect !== 1'b1 || pc_next !== 32'hFC) begin errors++; $display("FAIL br_taken got %b/%b/%h want 1/1/fc", cmp_eq, pc_redirect, pc_next); end
        sign_ext = 0; #1;
        checks++; if (pc_next !== 32'h0004_00FC) begin errors++; $display("FAIL br_zext got %h want 400fc", pc_next); end
        fwd_b = 2'b11; #1;
        checks++; if (cmp_eq !== 1'b0 || pc_redirect !== 1'b0) begin errors++; $display("FAIL br_not_taken got %b/%b want 0/0", cmp_eq, pc_redirect); end
        tick();
    endtask

    task automatic test_jump();
        idle();
        in_valid = 1; is_jump = 1; pc = 32'h8000_0010; inst = {6'h02, 26'h40}; #1;
        checks++; if (pc_redirect !== 1'b1 || pc_next !== 32'h8000_0100) begin errors++; $display("FAIL jmp got %b/%h want 1/80000100", pc_redirect, pc_next); end
        is_branch = 1; inst = {6'h02, 26'h40}; fwd_a = 2'b11; fwd_b = 2'b11; sign_ext = 1; #1;
        checks++; if (pc_next !== 32'h8000_0100) begin errors++; $display("FAIL jmp_wins got %h want 80000100", pc_next); end
        tick();
    endtask

    task automatic test_backpressure();
        idle(); in_valid = 0; tick();
        out_ready = 0; in_valid = 1; pc = 32'h200; inst = mk_inst(1, 2, 16'h0042); tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200) begin errors++; $display("FAIL bp_load got %b/%h want 1/200", out_valid, out_pc); end
        for (int k = 0; k < 3; k++) begin
            pc = $urandom; inst = $urandom; is_jump = 1; #1;
            checks++; if (in_ready !== 1'b0 || pc_redirect !== 1'b0) begin errors++; $display("FAIL bp_stall%0d got %b/%b want 0/0", k, in_ready, pc_redirect); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_imm !== 32'h42 || out_rd !== 5'd0) begin errors++; $display("FAIL bp_hold%0d got %b/%h/%h want 1/200/42", k, out_valid, out_pc, out_imm); end
        end
`ifdef ID_STALL_CNT_EN
        checks++; if (stall_cnt !== e_stall) begin errors++; $display("FAIL bp_stall_cnt got %0d want %0d", stall_cnt, e_stall); end
`endif
        out_ready = 1; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            rst         = ($urandom_range(0, 63) == 0);
            in_valid    = ($urandom_range(0, 3) != 0);
            pc          = $urandom;
            inst        = $urandom;
            inst[25:21] = 5'($urandom_range(0, 7));
            inst[20:16] = 5'($urandom_range(0, 7));
            sign_ext    = 1'($urandom_range(0, 1));
            is_branch   = ($urandom_range(0, 2) == 0);
            is_jump     = ($urandom_range(0, 4) == 0);
            wb_we       = 1'($urandom_range(0, 1));
            wb_addr     = 5'($urandom_range(0, 7));
            wb_data     = $urandom_range(0, 3);
            ex_out      = ($urandom_range(0, 1) == 0) ? wb_data : $urandom;
            fwd_a       = 2'($urandom_range(0, 3));
            fwd_b       = 2'($urandom_range(0, 3));
            ex_mem_read = ($urandom_range(0, 3) == 0);
            ex_rt       = 5'($urandom_range(0, 7));
            out_ready   = ($urandom_range(0, 3) != 0);
            #1;
            if (!rst) begin
                checks++; if (in_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready n=%0d got %b want %b", n, in_ready, m_ready()); end
                checks++; if (cmp_eq !== m_cmp()) begin errors++; $display("FAIL rnd_cmp n=%0d got %b want %b", n, cmp_eq, m_cmp()); end
                checks++; if (pc_redirect !== m_redirect()) begin errors++; $display("FAIL rnd_redir n=%0d got %b want %b", n, pc_redirect, m_redirect()); end
                if (m_redirect()) begin
                    checks++; if (pc_next !== m_pcnext()) begin errors++; $display("FAIL rnd_pcnext n=%0d got %h want %h", n, pc_next, m_pcnext()); end
                end
            end
            tick();
            checks++; if (out_valid !== e_valid) begin errors++; $display("FAIL rnd_valid n=%0d got %b want %b", n, out_valid, e_valid); end
            checks++; if (out_pc !== e_pc || out_imm !== e_imm) begin errors++; $display("FAIL rnd_pc_imm n=%0d got %h/%h want %h/%h", n, out_pc, out_imm, e_pc, e_imm); end
            checks++; if (out_rs_data !== e_rs_data || out_rt_data !== e_rt_data) begin errors++; $display("FAIL rnd_data n=%0d got %h/%h want %h/%h", n, out_rs_data, out_rt_data, e_rs_data, e_rt_data); end
            checks++; if ({out_rs, out_rt, out_rd} !== {e_rs, e_rt, e_rd}) begin errors++; $display("FAIL rnd_addr n=%0d got %h want %h", n, {out_rs, out_rt, out_rd}, {e_rs, e_rt, e_rd}); end
`ifdef ID_STALL_CNT_EN
            checks++; if (stall_cnt !== e_stall) begin errors++; $display("FAIL rnd_stall_cnt n=%0d got %0d want %0d", n, stall_cnt, e_stall); end
`endif
        end
    endtask

    initial begin
        idle();
        rst = 1;
        @(negedge clk);
        test_reset();
        test_regfile_wt();
        test_hazard();
        test_branch();
        test_jump();
        test_backpressure();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
